// File: rtl/mse_loss_fwd_pkg.sv
// rtl/mse_loss_fwd_pkg.sv - shared Q8.8 constants, widths and FSM states for mse_loss_fwd
package mse_loss_fwd_pkg;
    localparam int FRAC_BITS = 8;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 32;

    localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCALE = 2'd2
    } state_t;
endpackage

// File: rtl/fxp_addsub.sv
// rtl/fxp_addsub.sv - saturating signed fixed-point adder/subtractor
module fxp_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);
    logic signed [W:0] ext_a;
    logic signed [W:0] ext_b;
    logic signed [W:0] res;

    always_comb begin
        ext_a = {a[W-1], a};
        ext_b = sub ? -$signed({b[W-1], b}) : $signed({b[W-1], b});
        res   = ext_a + ext_b;
        // Disagreement between the two top bits means the true result left W-bit range.
        if (res[W] != res[W-1]) begin
            y = res[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = res[W-1:0];
        end
    end
endmodule

// File: rtl/mse_loss_fwd.sv
// rtl/mse_loss_fwd.sv - batch mean-squared-error loss in signed Q8.8
module mse_loss_fwd
    import mse_loss_fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [7:0]        batch_size_in,
    input  logic [DATA_W-1:0] inv_batch_size_in,
    input  logic [DATA_W-1:0] H_in,
    input  logic [DATA_W-1:0] Y_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic [DATA_W-1:0] loss_out,
    output logic              loss_valid_out,
    output logic              busy_out
);
    state_t            state_q;
    state_t            state_d;
    logic [7:0]        n_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] inv_q;
    logic [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0] loss_q;
    logic              loss_valid_q;

    logic                start_ok;
    logic                accept;
    logic                last;
    logic [DATA_W-1:0]   diff;
    logic signed [31:0]  prod_sq;
    logic [31:0]         sq_wide;
    logic [DATA_W-1:0]   sq;
    logic [ACC_W:0]      acc_sum;
    logic [ACC_W-1:0]    acc_next;
    logic signed [48:0]  scaled;
    logic signed [48:0]  scaled_sh;
    logic [DATA_W-1:0]   loss_sat;

    fxp_addsub #(.W(DATA_W)) u_diff (
        .a   (H_in),
        .b   (Y_in),
        .sub (1'b1),
        .y   (diff)
    );

    assign start_ok = (state_q == ST_IDLE) && start_in;
    assign accept   = valid_in && ready_out;
    assign last     = accept && (cnt_q == n_q - 8'd1);

    always_comb begin
        prod_sq  = $signed(diff) * $signed(diff);
        sq_wide  = $unsigned(prod_sq) >> FRAC_BITS;
        sq       = (sq_wide > 32'h0000_7FFF) ? SAT_MAX : sq_wide[DATA_W-1:0];
        acc_sum  = {1'b0, acc_q} + {{(ACC_W-DATA_W+1){1'b0}}, sq};
        acc_next = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
    end

    // Accumulator is unsigned, so it enters the multiply with a zero sign bit.
    always_comb begin
        scaled    = $signed({1'b0, acc_q}) * $signed(inv_q);
        scaled_sh = scaled >>> FRAC_BITS;
        if (scaled_sh > 49'sd32767) begin
            loss_sat = SAT_MAX;
        end else if (scaled_sh < -49'sd32768) begin
            loss_sat = SAT_MIN;
        end else begin
            loss_sat = scaled_sh[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d = (batch_size_in == 8'd0) ? ST_SCALE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last) begin
                    state_d = ST_SCALE;
                end
            end
            ST_SCALE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            n_q          <= '0;
            inv_q        <= '0;
            cnt_q        <= '0;
            acc_q        <= '0;
            loss_q       <= '0;
            loss_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            loss_valid_q <= (state_q == ST_SCALE);
            if (state_q == ST_SCALE) begin
                loss_q <= loss_sat;
            end
            if (start_ok) begin
                n_q   <= batch_size_in;
                inv_q <= inv_batch_size_in;
                cnt_q <= '0;
                acc_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + 8'd1;
                acc_q <= acc_next;
            end
        end
    end

    assign ready_out      = (state_q == ST_ACCUM);
    assign busy_out       = (state_q != ST_IDLE);
    assign loss_out       = loss_q;
    assign loss_valid_out = loss_valid_q;
endmodule

// File: doc/mse_loss_fwd.md
MSE_LOSS_FWD -- requirements
Module: mse_loss_fwd

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start_in, input, 1 bit: begin batch; sampled only in IDLE.
REQ-005 SHALL have port batch_size_in, input, 8 bits: sample count N, latched on accepted start.
REQ-006 SHALL have port inv_batch_size_in, input, 16 bits: signed Q8.8 value of 1/N, latched on accepted start.
REQ-007 SHALL have port H_in, input, 16 bits: signed Q8.8 prediction.
REQ-008 SHALL have port Y_in, input, 16 bits: signed Q8.8 target.
REQ-009 SHALL have port valid_in, input, 1 bit: the H_in/Y_in pair is valid.
REQ-010 SHALL have port ready_out, output, 1 bit: high only in ACCUM.
REQ-011 SHALL have port loss_out, output, 16 bits: signed Q8.8 batch MSE loss.
REQ-012 SHALL have port loss_valid_out, output, 1 bit: one-cycle pulse marking loss_out valid.
REQ-013 SHALL have port busy_out, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACCUM and SCALE; IDLE moves to ACCUM on start_in with N>0, or to SCALE on start_in with N=0; ACCUM moves to SCALE on acceptance of sample N; SCALE always moves to IDLE.
REQ-015 SHALL accept a sample only when valid_in and ready_out are both high; gaps in valid_in SHALL stall the batch without limit.
REQ-016 SHALL ignore valid_in while in IDLE or SCALE, and SHALL ignore start_in outside IDLE.
REQ-017 SHALL clear the accumulator and sample counter on an accepted start.
REQ-018 SHALL compute diff = H_in - Y_in, saturated to the signed 16-bit range.
REQ-019 SHALL compute sq = (diff*diff) >> 8, truncated, then saturated to 0x7FFF.
REQ-020 SHALL keep a 32-bit unsigned Q24.8 accumulator acc += sq, saturating at 0xFFFFFFFF with no wrap.
REQ-021 SHALL, in SCALE, compute loss = (acc * inv_batch_size_latched) >>> 8, truncated and saturated to the range [0x8000, 0x7FFF].
REQ-022 SHALL register loss into loss_out at the SCALE-exit edge and pulse loss_valid_out high for exactly one cycle.
REQ-023 SHALL produce loss_valid_out in cycle t+2 when the final sample is presented and accepted in cycle t.
REQ-024 SHALL produce loss_valid_out = 1 with loss_out = 0x0000 in cycle t+2 when a start with N=0 is accepted in cycle t.
REQ-025 SHALL hold loss_out at its last value until the next SCALE exit.
REQ-026 SHALL allow a new start_in to be accepted in the cycle in which loss_valid_out is high, since state is IDLE in that cycle.

Reset
REQ-027 SHALL, on rst, set state to IDLE and clear the accumulator, counter, latched N, latched 1/N, loss_out, loss_valid_out, busy_out and ready_out to 0.
REQ-028 SHALL abandon an in-progress batch when rst is asserted mid-batch, produce no loss pulse for it, and carry no stale accumulator state into later batches.

Structure
REQ-029 SHALL place the Q8.8 constants (FRAC_BITS=8, SAT_MAX=16'h7FFF, SAT_MIN=16'h8000), ACC_W=32 and the state enum in a shared package.
REQ-030 SHALL instantiate the existing fxp_addsub module, with sub tied to 1, for H_in - Y_in; squaring, accumulation and scaling SHALL be inline.

Verification
REQ-031 SHALL verify normal accumulation: N=4, inv=0x0040, H={0x0200,0x0100,0x0000,0x0300}, Y=0 -> loss_out=0x0380 (3.5), one-cycle pulse at t+2.
REQ-032 SHALL verify saturation: N=1, inv=0x0100, H=0x7F00, Y=0x8100 -> diff and sq saturate, loss_out=0x7FFF.
REQ-033 SHALL verify the empty batch: start with N=0 -> loss_valid_out in cycle t+2, loss_out=0x0000, no ACCUM cycle.
REQ-034 SHALL verify reset mid-batch: N=4, two samples accepted, rst pulsed, then N=1, inv=0x0100, H=0x0100, Y=0 -> loss_out=0x0100, and no pulse for the aborted batch.
REQ-035 SHALL verify stalls and ignored inputs: N=2 with a 3-cycle valid_in gap, valid_in pulsed in IDLE, start_in pulsed while busy -> exactly 2 samples counted, one loss pulse, correct value.
REQ-036 SHALL verify back-to-back batches: start asserted in the loss_valid_out cycle -> accepted, with the second batch's result independent of the first.
